vga_pixel_fetch: RTL and testbench
==================================

// Module: vga_pixel_fetch
// PURPOSE
//  Downstream consumer of the 640x480@60 VGA timing generator. Maps each screen
//  pixel to a 320x240 RGB444 frame-buffer location (2x upscale in both axes).
//  Issues pipelined reads, expands RGB444 to 8-bit channels, and delays
//  Hsync/Vsync/blank so that they stay aligned with the pixel data at the DAC.
// PARAMETERS
//  FB_W    320  frame-buffer width in pixels
//  FB_H    240  frame-buffer height in lines
//  RD_LAT  2    frame-buffer read latency in cycles, rd_addr -> rd_data (1..4)
//  AW      17   read address width; must satisfy 2^AW >= FB_W*FB_H
// PORTS
//  CLK25        in   1   25 MHz pixel clock, the only clock
//  Nreset       in   1   asynchronous active-low reset
//  Hcnt_in      in   10  horizontal count from the timing generator (0..799)
//  Vcnt_in      in   10  vertical count from the timing generator (0..524)
//  activeArea_in in  1   high while Hcnt<640 and Vcnt<480
//  Hsync_in     in   1   active-low horizontal sync
//  Vsync_in     in   1   active-low vertical sync
//  pattern_sel  in   1   select the colour-bar pattern (ignored without TEST_PATTERN_EN)
//  rd_en        out  1   frame-buffer read strobe
//  rd_addr      out  AW  frame-buffer read address, (Vcnt>>1)*FB_W + (Hcnt>>1)
//  rd_data      in   12  {R[3:0],G[3:0],B[3:0]}, valid RD_LAT cycles after rd_addr
//  R,G,B        out  8   each channel = {nibble,nibble}; 0 while blanking
//  Hsync_out    out  1   Hsync_in delayed by PIPE = RD_LAT+2 cycles
//  Vsync_out    out  1   Vsync_in delayed by PIPE
//  Nblank_out   out  1   activeArea_in delayed by PIPE
//  frame_start  out  1   one-cycle pulse when pixel (0,0) is presented on R/G/B
// BEHAVIOUR
//  - Reset values: rd_en=0, rd_addr=0, R=G=B=0, Hsync_out=1, Vsync_out=1,
//    Nblank_out=0, frame_start=0. All delay-line stages clear to the same inactive values.
//  - Stage 1 (registered): rd_en=activeArea_in. rd_addr is built from counters,
//    with no multiplier:
//    * row_base resets to 0 when Vcnt_in==524 && Hcnt_in==799.
//    * row_base += FB_W at Hcnt_in==639 when Vcnt_in is odd and Vcnt_in<480.
//    * col increments on odd Hcnt_in within active area; it clears at Hcnt_in==799.
//    * rd_addr = row_base + col. It holds its last value while rd_en=0.
//  - Stages 2..RD_LAT+1: the RAM access. rd_data is captured into the output register.
//  - Output register (total latency PIPE = RD_LAT+2 from the counter inputs):
//    * R/G/B are driven from the captured rd_data when delayed activeArea=1; otherwise 0.
//    * Sync and blank use a shift register of depth PIPE, so all outputs change on the same edge.
//  - Last pixel: (639,479) reads address 76799. No read is issued beyond FB_W*FB_H-1.
//  - frame_start is high only on the output cycle of pixel (0,0). There is exactly one pulse per frame.
//  - Counter jump (timing generator restarted): the address is re-derived from the counters
//    at the next line/frame boundary. This causes no lockup; at most one line is misaddressed.
//  - Reset mid-frame: everything clears immediately and asynchronously. After release, the
//    outputs are invalid for PIPE cycles (inactive values), then track the inputs normally.
// CONFIGURATION
//  - TEST_PATTERN_EN defined, pattern_sel=1:
//    * rd_en is forced 0.
//    * R/G/B show 8 vertical bars, each 80 px wide: white, yellow, cyan, green, magenta,
//      red, blue, black. Each channel is 8'hFF or 8'h00.
//    * Latency and sync alignment are identical to normal mode.
//  - TEST_PATTERN_EN undefined: pattern_sel is ignored and no pattern logic is synthesised.
// TESTING
//  1. Reset held 10 cycles with counters free-running -> all outputs at their reset values,
//     rd_en=0 throughout.
//  2. Free-run one frame, RD_LAT=2:
//     * (H,V)=(0,0) -> rd_addr=0; (1,0) -> 0; (2,0) -> 1.
//     * (0,1) -> 0; (0,2) -> 320; (639,479) -> 76799.
//  3. RAM model returns addr[11:0]:
//     * R/G/B for each pixel appear exactly 4 cycles after its counters are presented.
//     * Hsync_out falls 4 cycles after Hsync_in.
//     * frame_start pulses once, at 4 cycles after (0,0).
//  4. rd_data=12'hF0A on a visible pixel -> R=8'hFF, G=8'h00, B=8'hAA.
//     During blanking with rd_data=12'hFFF -> R=G=B=0.
//  5. Nreset asserted at (300,200) for 3 cycles -> outputs reset immediately.
//     The next frame's rd_addr sequence matches test 2 exactly.
//  6. TEST_PATTERN_EN defined, pattern_sel=1:
//     * Hcnt 0..79 -> RGB=FFFFFF; 80..159 -> FFFF00; 560..639 -> 000000.
//     * rd_en stays 0.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: turns 640x480 VGA timing counters into frame-buffer reads
// (320x240 RGB444, 2x upscale), expands the returned pixels to 8-bit channels
// and delays Hsync/Vsync/blank by PIPE = RD_LAT+2 cycles so that everything
// leaves the output register on the same edge.
// Optional feature: define TEST_PATTERN_EN to add an 8-bar colour pattern
// selected by pattern_sel; without it pattern_sel is ignored.
module vga_pixel_fetch #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int RD_LAT = 2,
  parameter int AW     = 17
) (
  input  logic          CLK25,
  input  logic          Nreset,
  input  logic [9:0]    Hcnt_in,
  input  logic [9:0]    Vcnt_in,
  input  logic          activeArea_in,
  input  logic          Hsync_in,
  input  logic          Vsync_in,
  input  logic          pattern_sel,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [11:0]   rd_data,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B,
  output logic          Hsync_out,
  output logic          Vsync_out,
  output logic          Nblank_out,
  output logic          frame_start
);

  localparam int PIPE = RD_LAT + 2;
  // Side-band stages between the stage-1 register and the output register.
  localparam int SB_D = PIPE - 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_W * FB_H - 1);
  localparam logic [AW-1:0] FB_W_A    = AW'(FB_W);

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic fs;
  } sb_t;

  localparam sb_t SB_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0};

  // Line start address for frame-buffer row vhalf, built by shift-and-add of
  // the constant FB_W so no general multiplier is needed.
  function automatic logic [AW-1:0] row_offset(input logic [8:0] vhalf);
    logic [AW+9:0] acc;
    acc = '0;
    for (int i = 0; i < AW; i++) begin
      if (FB_W_A[i]) begin
        acc = acc + ({{(AW + 1){1'b0}}, vhalf} << i);
      end else begin
        acc = acc;
      end
    end
    return acc[AW-1:0];
  endfunction

  // Stage-1 address generation state
  logic [AW-1:0] row_base_d, row_base_q;
  logic [AW-1:0] col_d, col_q;
  logic [AW-1:0] rd_addr_d, rd_addr_q;
  logic          rd_en_d, rd_en_q;
  logic [AW-1:0] addr_s;
  logic [9:0]    vnext_s;
  logic          pat_on_s;

  // Side-band delay line (sync, blank, frame marker)
  sb_t sb_d [SB_D];
  sb_t sb_q [SB_D];
  sb_t sb_last_s;

  // Output register
  logic [7:0] r_d, r_q, g_d, g_q, b_d, b_q;
  logic       hsync_d, hsync_q, vsync_d, vsync_q, nblank_d, nblank_q, fs_d, fs_q;

`ifdef TEST_PATTERN_EN
  logic       pat_d [SB_D];
  logic       pat_q [SB_D];
  logic [2:0] bar_d [SB_D];
  logic [2:0] bar_q [SB_D];
  logic [2:0] bar_s;
  assign pat_on_s = pattern_sel;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pat_on_s = 1'b0;
`endif

  // Stage 1: row/column counters and the registered read request
  always_comb begin
    vnext_s = (Vcnt_in >= 10'd524) ? 10'd0 : Vcnt_in + 10'd1;

    // The row base is re-derived from the counters at every line end so a
    // restarted timing generator misaddresses at most one line.
    if (Hcnt_in == 10'd799 && Vcnt_in == 10'd524) begin
      row_base_d = '0;
    end else if (Hcnt_in == 10'd799) begin
      row_base_d = row_offset(vnext_s[9:1]);
    end else if (Hcnt_in == 10'd639 && Vcnt_in[0] && Vcnt_in < 10'd480) begin
      row_base_d = row_base_q + FB_W_A;
    end else begin
      row_base_d = row_base_q;
    end

    if (Hcnt_in == 10'd799) begin
      col_d = '0;
    end else if (activeArea_in && Hcnt_in[0]) begin
      col_d = col_q + AW'(1);
    end else begin
      col_d = col_q;
    end

    addr_s    = row_base_q + col_q;
    rd_en_d   = activeArea_in && !pat_on_s && (addr_s <= LAST_ADDR);
    rd_addr_d = rd_en_d ? addr_s : rd_addr_q;
  end

  // Side-band shift: new entry from the timing inputs, older entries move on
  always_comb begin
    sb_d[0] = '{hs:  Hsync_in,
                vs:  Vsync_in,
                act: activeArea_in,
                fs:  activeArea_in && (Hcnt_in == 10'd0) && (Vcnt_in == 10'd0)};
    for (int k = 1; k < SB_D; k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

`ifdef TEST_PATTERN_EN
  // Bar colour {r,g,b} for the current column and its alignment delay line
  always_comb begin
    if (Hcnt_in < 10'd80) begin
      bar_s = 3'b111;
    end else if (Hcnt_in < 10'd160) begin
      bar_s = 3'b110;
    end else if (Hcnt_in < 10'd240) begin
      bar_s = 3'b011;
    end else if (Hcnt_in < 10'd320) begin
      bar_s = 3'b010;
    end else if (Hcnt_in < 10'd400) begin
      bar_s = 3'b101;
    end else if (Hcnt_in < 10'd480) begin
      bar_s = 3'b100;
    end else if (Hcnt_in < 10'd560) begin
      bar_s = 3'b001;
    end else begin
      bar_s = 3'b000;
    end
    pat_d[0] = pattern_sel;
    bar_d[0] = bar_s;
    for (int k = 1; k < SB_D; k++) begin
      pat_d[k] = pat_q[k-1];
      bar_d[k] = bar_q[k-1];
    end
  end

  // Pattern delay-line registers
  always_ff @(posedge CLK25 or negedge Nreset) begin
    if (!Nreset) begin
      for (int k = 0; k < SB_D; k++) begin
        pat_q[k] <= 1'b0;
        bar_q[k] <= 3'b000;
      end
    end else begin
      for (int k = 0; k < SB_D; k++) begin
        pat_q[k] <= pat_d[k];
        bar_q[k] <= bar_d[k];
      end
    end
  end
`endif

  // Output stage: expand captured RGB444 (or pattern) and blank outside active area
  always_comb begin
    sb_last_s = sb_q[SB_D-1];
    if (sb_last_s.act) begin
      r_d = {rd_data[11:8], rd_data[11:8]};
      g_d = {rd_data[7:4], rd_data[7:4]};
      b_d = {rd_data[3:0], rd_data[3:0]};
`ifdef TEST_PATTERN_EN
      if (pat_q[SB_D-1]) begin
        r_d = {8{bar_q[SB_D-1][2]}};
        g_d = {8{bar_q[SB_D-1][1]}};
        b_d = {8{bar_q[SB_D-1][0]}};
      end else begin
        r_d = r_d;
        g_d = g_d;
        b_d = b_d;
      end
`endif
    end else begin
      r_d = 8'h00;
      g_d = 8'h00;
      b_d = 8'h00;
    end
    hsync_d  = sb_last_s.hs;
    vsync_d  = sb_last_s.vs;
    nblank_d = sb_last_s.act;
    fs_d     = sb_last_s.fs;
  end

  // All pipeline registers; reset puts every stage in its inactive state
  always_ff @(posedge CLK25 or negedge Nreset) begin
    if (!Nreset) begin
      row_base_q <= '0;
      col_q      <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      for (int k = 0; k < SB_D; k++) begin
        sb_q[k] <= SB_IDLE;
      end
      r_q      <= 8'h00;
      g_q      <= 8'h00;
      b_q      <= 8'h00;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      nblank_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      row_base_q <= row_base_d;
      col_q      <= col_d;
      rd_addr_q  <= rd_addr_d;
      rd_en_q    <= rd_en_d;
      for (int k = 0; k < SB_D; k++) begin
        sb_q[k] <= sb_d[k];
      end
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      nblank_q <= nblank_d;
      fs_q     <= fs_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign R           = r_q;
  assign G           = g_q;
  assign B           = b_q;
  assign Hsync_out   = hsync_q;
  assign Vsync_out   = vsync_q;
  assign Nblank_out  = nblank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch. Timing counters are driven in line
// segments (with deliberate jumps during blanking to keep frames short), a
// RAM model with RD_LAT cycles of latency serves reads, and the expected
// outputs of every cycle are queued and compared PIPE cycles later.
module tb_vga_pixel_fetch;

  localparam int RD_LAT = 2;
  localparam int PIPE   = RD_LAT + 2;
  localparam int AW     = 17;

  logic          CLK25 = 1'b0;
  logic          Nreset;
  logic [9:0]    Hcnt_in, Vcnt_in;
  logic          activeArea_in, Hsync_in, Vsync_in, pattern_sel;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [11:0]   rd_data;
  logic [7:0]    R, G, B;
  logic          Hsync_out, Vsync_out, Nblank_out, frame_start;

  always #20 CLK25 = ~CLK25;

  vga_pixel_fetch #(.FB_W(320), .FB_H(240), .RD_LAT(RD_LAT), .AW(AW)) dut (
    .CLK25(CLK25), .Nreset(Nreset), .Hcnt_in(Hcnt_in), .Vcnt_in(Vcnt_in),
    .activeArea_in(activeArea_in), .Hsync_in(Hsync_in), .Vsync_in(Vsync_in),
    .pattern_sel(pattern_sel), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .R(R), .G(G), .B(B), .Hsync_out(Hsync_out), .Vsync_out(Vsync_out),
    .Nblank_out(Nblank_out), .frame_start(frame_start)
  );

  // RAM contents: address low bits, with two marked words for colour checks
  function automatic logic [11:0] ram_word(input logic [AW-1:0] a);
    if (a == 17'd5) return 12'hF0A;
    else if (a == 17'd319) return 12'hFFF;
    else return a[11:0];
  endfunction

  // RAM model: data appears RD_LAT cycles after the address
  logic [AW-1:0] ram_pipe [RD_LAT];
  always @(posedge CLK25) begin
    ram_pipe[0] <= rd_addr;
    for (int k = 1; k < RD_LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
  end
  assign rd_data = ram_word(ram_pipe[RD_LAT-1]);

  typedef struct packed {
    logic        chk;
    logic [23:0] rgb;
    logic [3:0]  sbf;   // {Hsync, Vsync, Nblank, frame_start}
  } out_exp_t;

  typedef struct packed {
    logic          chk;
    logic          en;
    logic [AW-1:0] addr;
  } addr_exp_t;

  localparam out_exp_t OUT_IDLE = '{chk: 1'b1, rgb: 24'h000000, sbf: 4'b1100};

  out_exp_t  oq[$];
  addr_exp_t aq[$];
  int checks_cnt = 0;
  int errors_cnt = 0;
  int fs_seen    = 0;
  logic [AW-1:0] last_addr;
  bit addr_known;
  bit line_ok;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] expand(input logic [11:0] d);
    return {d[11:8], d[11:8], d[7:4], d[7:4], d[3:0], d[3:0]};
  endfunction

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Async reset empties the pipeline: every pending expectation becomes idle
  task automatic reset_flush();
    foreach (oq[k]) oq[k] = OUT_IDLE;
    foreach (aq[k]) aq[k] = '{chk: 1'b1, en: 1'b0, addr: '0};
    last_addr  = '0;
    addr_known = 1'b1;
    line_ok    = 1'b0;
  endtask

  task automatic step(input int h, input int v, input bit rstn, input bit psel);
    out_exp_t  o;
    addr_exp_t a;
    logic act, pat;
    @(posedge CLK25);
    #1;
    act           = (h < 640) && (v < 480);
    Hcnt_in       = 10'(h);
    Vcnt_in       = 10'(v);
    activeArea_in = act;
    Hsync_in      = !(h >= 656 && h < 752);
    Vsync_in      = !(v >= 490 && v < 492);
    pattern_sel   = psel;
    if (!rstn) begin
      if (Nreset) reset_flush();
      Nreset = 1'b0;
      o = OUT_IDLE;
      a = '{chk: 1'b1, en: 1'b0, addr: '0};
    end else begin
      Nreset = 1'b1;
`ifdef TEST_PATTERN_EN
      pat = psel;
`else
      pat = 1'b0;
`endif
      o.chk = 1'b1;
      o.sbf = {Hsync_in, Vsync_in, act, act && (h == 0) && (v == 0)};
      if (!act) o.rgb = 24'h0;
      else if (pat) o.rgb = bar_rgb(h / 80);
      else if (!line_ok) begin o.chk = 1'b0; o.rgb = 24'h0; end
      else o.rgb = expand(ram_word(AW'((v / 2) * 320 + h / 2)));
      if (act && !pat) begin
        if (line_ok) begin
          last_addr  = AW'((v / 2) * 320 + h / 2);
          addr_known = 1'b1;
          a = '{chk: 1'b1, en: 1'b1, addr: last_addr};
        end else begin
          addr_known = 1'b0;
          a = '{chk: 1'b0, en: 1'b1, addr: '0};
        end
      end else begin
        a = '{chk: addr_known, en: 1'b0, addr: last_addr};
      end
      if (h == 799) line_ok = 1'b1;
    end
    oq.push_back(o);
    aq.push_back(a);
    @(negedge CLK25);
    if (aq.size() > 1) begin
      a = aq.pop_front();
      check_eq("rd_en", 32'(rd_en), 32'(a.en));
      if (a.chk) check_eq("rd_addr", 32'(rd_addr), 32'(a.addr));
    end
    if (oq.size() > PIPE) begin
      o = oq.pop_front();
      if (o.chk) check_eq("rgb", 32'({R, G, B}), 32'(o.rgb));
      check_eq("sync_blank_fs", 32'({Hsync_out, Vsync_out, Nblank_out, frame_start}), 32'(o.sbf));
    end
    if (frame_start) fs_seen++;
  endtask

  task automatic run_line(input int v, input bit psel);
    for (int h = 0; h < 800; h++) step(h, v, 1'b1, psel);
  endtask

  // Shortened frame: lines 0..3, optional reset line 200, lines 477..479,
  // vsync line 490, then the frame-end corner (799,524)
  task automatic run_frame(input bit rst_mid, input bit psel);
    fs_seen = 0;
    for (int v = 0; v < 4; v++) run_line(v, psel);
    if (rst_mid) begin
      step(798, 199, 1'b1, psel);
      step(799, 199, 1'b1, psel);
      for (int h = 0; h < 800; h++) step(h, 200, !(h >= 300 && h < 303), psel);
    end
    step(798, 476, 1'b1, psel);
    step(799, 476, 1'b1, psel);
    for (int v = 477; v < 480; v++) run_line(v, psel);
    step(798, 489, 1'b1, psel);
    step(799, 489, 1'b1, psel);
    run_line(490, psel);
    step(798, 524, 1'b1, psel);
    step(799, 524, 1'b1, psel);
    check_eq("frame_start_count", 32'(fs_seen), 32'd1);
  endtask

  initial begin
    Nreset        = 1'b0;
    Hcnt_in       = 10'd0;
    Vcnt_in       = 10'd0;
    activeArea_in = 1'b0;
    Hsync_in      = 1'b1;
    Vsync_in      = 1'b1;
    pattern_sel   = 1'b0;
    last_addr     = '0;
    addr_known    = 1'b1;
    line_ok       = 1'b0;
    for (int k = 0; k < PIPE; k++) oq.push_back(OUT_IDLE);
    aq.push_back('{chk: 1'b1, en: 1'b0, addr: '0});

    // Reset held 10 cycles with counters running, then release in blanking
    for (int h = 780; h < 790; h++) step(h, 524, 1'b0, 1'b0);
    for (int h = 790; h < 800; h++) step(h, 524, 1'b1, 1'b0);

    run_frame(1'b0, 1'b0);   // normal frame
    run_frame(1'b1, 1'b0);   // reset pulse at (300,200)
    run_frame(1'b0, 1'b0);   // next frame must address exactly as the first
    run_frame(1'b0, 1'b1);   // pattern_sel high

    // Drain the pipeline in blanking
    for (int h = 0; h < PIPE + 2; h++) step(h, 500, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
